// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI burst/response types, channel FSM states and beat-address stepping
package axi_pkg;
  localparam int AW_MAX = 64;
  typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2} burst_t;
  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} resp_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} rstate_t;
  // WRAP and reserved encodings step like INCR; callers truncate to their address width
  function automatic logic [AW_MAX-1:0] next_beat_addr(input logic [AW_MAX-1:0] addr,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
    return (burst == FIXED) ? addr : addr + (AW_MAX'(1) << size);
  endfunction
endpackage

// File: rtl/axi_if.sv
// axi_if: AXI4 bundle with slave (axi_s) and master (axi_m) views
interface axi_if #(
  parameter int ID_W_WIDTH = 4,
  parameter int ID_R_WIDTH = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
  logic [ID_W_WIDTH-1:0] AWID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWVALID, AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [NBYTES-1:0]     WSTRB;
  logic                  WLAST, WVALID, WREADY;
  logic [ID_W_WIDTH-1:0] BID;
  logic [1:0]            BRESP;
  logic                  BVALID, BREADY;
  logic [ID_R_WIDTH-1:0] ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID, ARREADY;
  logic [ID_R_WIDTH-1:0] RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST, RVALID, RREADY;
  modport axi_s (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WDATA, WSTRB, WLAST, WVALID, BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
  modport axi_m (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WDATA, WSTRB, WLAST, WVALID, BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/ram_bytewrite.sv
// ram_bytewrite: byte-enabled write port plus registered read-first read port
module ram_bytewrite #(
  parameter int DEPTH      = 16384,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int AW         = $clog2(DEPTH),
  parameter int NB         = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [NB-1:0]         be,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (we && be[i]) mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 RAM slave with independent write and read burst FSMs
module axi_ram_slave
  import axi_pkg::*;
#(
  parameter int ID_W_WIDTH = 4,
  parameter int ID_R_WIDTH = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input logic  clk,
  input logic  rst_n,
  axi_if.axi_s axi_s
);
  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int LB     = $clog2(NBYTES);
  localparam int DEPTH  = (2 ** ADDR_WIDTH) / NBYTES;
  wstate_t ws, ws_n;
  rstate_t rs, rs_n;
  logic [ID_W_WIDTH-1:0] wid;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [7:0]            wlen, wcnt;
  logic [2:0]            wsize;
  logic [1:0]            wburst;
  logic                  awready;
  logic [ID_R_WIDTH-1:0] rid;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [7:0]            rlen, rcnt;
  logic [2:0]            rsize;
  logic [1:0]            rburst;
  logic                  arready;
  logic [DATA_WIDTH-1:0] ram_q;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, r_last;
  assign aw_hs  = axi_s.AWVALID && awready;
  assign w_hs   = (ws == W_DATA) && axi_s.WVALID;
  assign b_hs   = (ws == W_RESP) && axi_s.BREADY;
  assign ar_hs  = axi_s.ARVALID && arready;
  assign r_hs   = (rs == R_SEND) && axi_s.RREADY;
  assign r_last = rcnt == rlen;
  // an early WLAST closes the burst even if fewer than LEN+1 beats arrived
  always_comb begin
    ws_n = aw_hs ? W_DATA :
           (w_hs && (wcnt == wlen || axi_s.WLAST)) ? W_RESP :
           b_hs ? W_IDLE : ws;
    rs_n = ar_hs ? R_FETCH :
           (rs == R_FETCH) ? R_SEND :
           r_hs ? (r_last ? R_IDLE : R_FETCH) : rs;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws      <= W_IDLE;
      awready <= 1'b0;
      wid     <= '0;
      waddr   <= '0;
      wlen    <= '0;
      wcnt    <= '0;
      wsize   <= '0;
      wburst  <= '0;
    end else begin
      ws      <= ws_n;
      awready <= ws_n == W_IDLE;
      if (aw_hs) begin
        wid    <= axi_s.AWID;
        waddr  <= axi_s.AWADDR;
        wlen   <= axi_s.AWLEN;
        wsize  <= axi_s.AWSIZE;
        wburst <= axi_s.AWBURST;
        wcnt   <= '0;
      end
      if (w_hs) begin
        waddr <= ADDR_WIDTH'(next_beat_addr(AW_MAX'(waddr), wsize, wburst));
        wcnt  <= wcnt + 8'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs      <= R_IDLE;
      arready <= 1'b0;
      rid     <= '0;
      raddr   <= '0;
      rlen    <= '0;
      rcnt    <= '0;
      rsize   <= '0;
      rburst  <= '0;
    end else begin
      rs      <= rs_n;
      arready <= rs_n == R_IDLE;
      if (ar_hs) begin
        rid    <= axi_s.ARID;
        raddr  <= axi_s.ARADDR;
        rlen   <= axi_s.ARLEN;
        rsize  <= axi_s.ARSIZE;
        rburst <= axi_s.ARBURST;
        rcnt   <= '0;
      end
      if (r_hs) begin
        raddr <= ADDR_WIDTH'(next_beat_addr(AW_MAX'(raddr), rsize, rburst));
        rcnt  <= rcnt + 8'd1;
      end
    end
  end
  ram_bytewrite #(
    .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .BYTE_WIDTH(BYTE_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (w_hs),
    .waddr(waddr[ADDR_WIDTH-1:LB]),
    .be   (axi_s.WSTRB),
    .wdata(axi_s.WDATA),
    .re   (rs == R_FETCH),
    .raddr(raddr[ADDR_WIDTH-1:LB]),
    .rdata(ram_q)
  );
  assign axi_s.AWREADY = awready;
  assign axi_s.WREADY  = ws == W_DATA;
  assign axi_s.BVALID  = ws == W_RESP;
  assign axi_s.BID     = wid;
  assign axi_s.BRESP   = OKAY;
  assign axi_s.ARREADY = arready;
  assign axi_s.RVALID  = rs == R_SEND;
  assign axi_s.RLAST   = (rs == R_SEND) && r_last;
  assign axi_s.RID     = rid;
  assign axi_s.RRESP   = OKAY;
  // the RAM output register has no reset, so RDATA is masked outside SEND
  assign axi_s.RDATA   = (rs == R_SEND) ? ram_q : '0;
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed and randomized bursts checked against a byte-array memory model
module tb_axi_ram_slave;
  localparam int IW = 4, AW = 16, DW = 32, BW = 8, NB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  axi_if #(.ID_W_WIDTH(IW), .ID_R_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus ();
  axi_ram_slave #(.ID_W_WIDTH(IW), .ID_R_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .axi_s(bus)
  );
  int total = 0, bad = 0;
  logic [7:0]    mem_m [1 << AW];
  logic [DW-1:0] wd [256];
  logic [NB-1:0] wsb [256];
  logic [DW-1:0] rq [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] step(input logic [AW-1:0] a, input int size, input int burst);
    return (burst == 0) ? a : AW'(32'(a) + (32'd1 << size));
  endfunction

  function automatic logic [DW-1:0] model_word(input logic [AW-1:0] a);
    logic [AW-1:0] b = {a[AW-1:2], 2'b00};
    return {mem_m[b + 3], mem_m[b + 2], mem_m[b + 1], mem_m[b]};
  endfunction

  function automatic logic [63:0] outs();
    return 64'({bus.AWREADY, bus.WREADY, bus.BVALID, bus.BID, bus.BRESP,
                bus.ARREADY, bus.RVALID, bus.RLAST, bus.RID, bus.RRESP, bus.RDATA});
  endfunction

  task automatic wr(input logic [IW-1:0] id, input int addr, len, size, burst, nbeats, hold, abort);
    int n;
    logic [AW-1:0] a = AW'(addr);
    logic [AW-1:0] b;
    bus.AWID = id; bus.AWADDR = a; bus.AWLEN = 8'(len); bus.AWSIZE = 3'(size);
    bus.AWBURST = 2'(burst); bus.AWVALID = 1'b1;
    n = 0;
    while (!bus.AWREADY && n < 50) begin tick(); n++; end
    check("aw_wait", 64'(n < 50), 1);
    tick();
    bus.AWVALID = 1'b0;
    check("aw_drop", 64'(bus.AWREADY), 0);
    for (int i = 0; i < nbeats; i++) begin
      bus.WVALID = 1'b0;
      if ($urandom_range(3) == 0) tick();
      bus.WVALID = 1'b1; bus.WDATA = wd[i]; bus.WSTRB = wsb[i]; bus.WLAST = (i == nbeats - 1);
      if (i == abort) begin
        rst_n = 1'b0;
        #1;
        check("rst_out", outs(), 0);
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        return;
      end
      n = 0;
      while (!bus.WREADY && n < 50) begin tick(); n++; end
      check("w_wait", 64'(n < 50), 1);
      tick();
      b = {a[AW-1:2], 2'b00};
      for (int l = 0; l < NB; l++)
        if (wsb[i][l]) mem_m[b + AW'(l)] = wd[i][l*8 +: 8];
      a = step(a, size, burst);
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    n = 0;
    while (!bus.BVALID && n < 50) begin tick(); n++; end
    check("b_wait", 64'(n < 50), 1);
    check("w_after", 64'(bus.WREADY), 0);
    check("bid", 64'(bus.BID), 64'(id));
    check("bresp", 64'(bus.BRESP), 0);
    repeat (hold) begin
      tick();
      check("b_hold", 64'({bus.BVALID, bus.BID, bus.BRESP}), 64'({1'b1, id, 2'b00}));
    end
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    check("b_done", 64'(bus.BVALID), 0);
  endtask

  task automatic rd(input logic [IW-1:0] id, input int addr, len, size, burst, hold);
    int n;
    logic [AW-1:0] a = AW'(addr);
    logic [DW-1:0] exp;
    bus.ARID = id; bus.ARADDR = a; bus.ARLEN = 8'(len); bus.ARSIZE = 3'(size);
    bus.ARBURST = 2'(burst); bus.ARVALID = 1'b1;
    n = 0;
    while (!bus.ARREADY && n < 50) begin tick(); n++; end
    check("ar_wait", 64'(n < 50), 1);
    tick();
    bus.ARVALID = 1'b0;
    check("ar_drop", 64'(bus.ARREADY), 0);
    for (int i = 0; i <= len; i++) begin
      n = 0;
      while (!bus.RVALID && n < 50) begin tick(); n++; end
      check("r_wait", 64'(n < 50), 1);
      exp = model_word(a);
      check("rdata", 64'(bus.RDATA), 64'(exp));
      check("rid", 64'(bus.RID), 64'(id));
      check("rresp", 64'(bus.RRESP), 0);
      check("rlast", 64'(bus.RLAST), 64'(i == len));
      rq.push_back(bus.RDATA);
      repeat (hold) begin
        tick();
        check("r_hold", 64'({bus.RVALID, bus.RLAST, bus.RDATA}), 64'({1'b1, i == len, exp}));
      end
      bus.RREADY = 1'b1;
      tick();
      bus.RREADY = 1'b0;
      check("r_gap", 64'(bus.RVALID), 0);
      a = step(a, size, burst);
    end
    repeat (3) tick();
    check("r_extra", 64'(bus.RVALID), 0);
  endtask

  initial begin
    int len, size, burst, addr, nb;
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = 8'h00;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;
    #1;
    check("reset_outs", outs(), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    wd[0] = 32'hFFFF_FFFF; wsb[0] = 4'b1001;
    wd[1] = 32'h89AB_CDEF; wsb[1] = 4'hF;
    wd[2] = 32'h0123_4567; wsb[2] = 4'hF;
    wr(4'd1, 1, 2, 2, 1, 3, 5, -1);
    rq.delete();
    rd(4'd1, 1, 2, 2, 1, 5);
    check("dir_w0", 64'(rq[0]), 64'h0000_0000_FF00_00FF);
    check("dir_w1", 64'(rq[1]), 64'h0000_0000_89AB_CDEF);
    check("dir_w2", 64'(rq[2]), 64'h0000_0000_0123_4567);
    for (int i = 0; i < 4; i++) begin wd[i] = DW'(i + 1); wsb[i] = 4'hF; end
    wr(4'd2, 'h10, 3, 2, 0, 4, 0, -1);
    rq.delete();
    rd(4'd2, 'h10, 3, 2, 1, 0);
    check("fixed_w4", 64'(rq[0]), 4);
    check("fixed_w5", 64'(rq[1]), 0);
    check("fixed_w7", 64'(rq[3]), 0);
    wd[0] = 32'hA5A5_0001; wd[1] = 32'hA5A5_0002;
    wr(4'd3, 'h100, 3, 2, 1, 4, 0, 1);
    tick();
    rst_n = 1'b1;
    tick();
    wd[0] = 32'h5A5A_1234; wsb[0] = 4'hF;
    wr(4'd4, 'h200, 0, 2, 1, 1, 1, -1);
    rq.delete();
    rd(4'd4, 'h100, 1, 2, 1, 0);
    check("rst_keep", 64'(rq[0]), 64'hA5A5_0001);
    check("rst_drop", 64'(rq[1]), 0);
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE_0000 + DW'(i); wsb[i] = 4'hF; end
    wr(4'd5, 'h20, 3, 2, 1, 4, 0, -1);
    wd[0] = 32'hDEAD_BEEF;
    rq.delete();
    fork
      wr(4'd6, 0, 0, 2, 1, 1, 2, -1);
      rd(4'd7, 'h20, 3, 2, 1, 1);
    join
    check("conc_r0", 64'(rq[0]), 64'hC0DE_0000);
    check("conc_r3", 64'(rq[3]), 64'hC0DE_0003);
    wd[0] = 32'h1111_2222; wd[1] = 32'h3333_4444; wsb[0] = 4'hF; wsb[1] = 4'hF;
    wr(4'd8, 'hFFFC, 1, 2, 1, 2, 0, -1);
    rq.delete();
    rd(4'd8, 'hFFFC, 1, 2, 1, 0);
    check("wrap_hi", 64'(rq[0]), 64'h1111_2222);
    check("wrap_lo", 64'(rq[1]), 64'h3333_4444);
    for (int t = 0; t < 25; t++) begin
      len = $urandom_range(0, 7);
      size = $urandom_range(0, 2);
      burst = $urandom_range(0, 3);
      addr = $urandom_range(0, 255);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 1) : len + 1;
      for (int i = 0; i < nb; i++) begin wd[i] = $urandom; wsb[i] = 4'($urandom); end
      wr(4'(t), addr, len, size, burst, nb, $urandom_range(0, 3), -1);
      rd(4'(t + 3), $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 2),
         $urandom_range(0, 3), $urandom_range(0, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
